// File: rtl/fifo_wr_packer.sv
// Packs IN_WIDTH-bit lanes into RATIO-lane words for an async FIFO write port.
// Ports: W_CLK/RST_N_W_CLK; S_VALID/S_READY/S_DATA/S_LAST lane input;
// FULL/W_EN/DATA_IN FIFO write side; PKT_CNT packets written; BUSY activity.
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 16,
    localparam int LW        = $clog2(RATIO),
    localparam int DW        = IN_WIDTH * RATIO,
    localparam int OUT_WIDTH = DW + LW + 1
) (
    input  logic                 W_CLK,
    input  logic                 RST_N_W_CLK,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [IN_WIDTH-1:0]  S_DATA,
    input  logic                 S_LAST,
    input  logic                 FULL,
    output logic                 W_EN,
    output logic [OUT_WIDTH-1:0] DATA_IN,
    output logic [CNT_WIDTH-1:0] PKT_CNT,
    output logic                 BUSY
);

    logic [DW-1:0]        acc;
    logic [LW-1:0]        idx;
    logic [OUT_WIDTH-1:0] out_word;
    logic                 out_pending;
    logic [CNT_WIDTH-1:0] pkt_cnt;

    logic                 accept;
    logic                 complete;
    logic [DW-1:0]        lane_sh;

    // A pending word blocks input only while the FIFO is full; otherwise it
    // drains in the same cycle a new lane (possibly completing a word) lands.
    assign S_READY  = !out_pending || !FULL;
    assign W_EN     = out_pending && !FULL;
    assign DATA_IN  = out_pending ? out_word : '0;
    assign PKT_CNT  = pkt_cnt;
    assign BUSY     = (idx != '0) || out_pending;

    assign accept   = S_VALID && S_READY;
    assign complete = (idx == LW'(RATIO - 1)) || S_LAST;

    always_comb begin
        lane_sh = '0;
        lane_sh[idx*IN_WIDTH +: IN_WIDTH] = S_DATA;
    end

    always_ff @(posedge W_CLK or negedge RST_N_W_CLK) begin
        if (!RST_N_W_CLK) begin
            acc         <= '0;
            idx         <= '0;
            out_word    <= '0;
            out_pending <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    out_word <= {S_LAST, idx, acc | lane_sh};
                    acc      <= '0;
                    idx      <= '0;
                end else begin
                    acc <= acc | lane_sh;
                    idx <= idx + 1'b1;
                end
            end
            // A load in the same cycle as a write keeps the flag set.
            if (accept && complete) begin
                out_pending <= 1'b1;
            end else if (W_EN) begin
                out_pending <= 1'b0;
            end
            if (W_EN && out_word[OUT_WIDTH-1]) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_wen_not_full : assert property (
        @(posedge W_CLK) disable iff (!RST_N_W_CLK)
        W_EN |-> !FULL);

    a_hold_on_full : assert property (
        @(posedge W_CLK) disable iff (!RST_N_W_CLK)
        (out_pending && FULL) |=> $stable(out_word));
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer (IN_WIDTH=8, RATIO=4).
// Stimulus pushes hand-computed words; a negedge monitor pops and compares.
module tb_fifo_wr_packer;

    localparam int IW = 8;
    localparam int RT = 4;
    localparam int CW = 16;
    localparam int OW = 35;

    logic          W_CLK;
    logic          RST_N_W_CLK;
    logic          S_VALID;
    logic          S_READY;
    logic [IW-1:0] S_DATA;
    logic          S_LAST;
    logic          FULL;
    logic          W_EN;
    logic [OW-1:0] DATA_IN;
    logic [CW-1:0] PKT_CNT;
    logic          BUSY;

    int vectors;
    int miscompares;
    int cyc;

    logic [OW-1:0] exp_q[$];
    int            wen_cyc[$];
    logic          prev_stall;
    logic [OW-1:0] prev_data;

    fifo_wr_packer #(
        .IN_WIDTH  (IW),
        .RATIO     (RT),
        .CNT_WIDTH (CW)
    ) dut (
        .W_CLK       (W_CLK),
        .RST_N_W_CLK (RST_N_W_CLK),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .S_DATA      (S_DATA),
        .S_LAST      (S_LAST),
        .FULL        (FULL),
        .W_EN        (W_EN),
        .DATA_IN     (DATA_IN),
        .PKT_CNT     (PKT_CNT),
        .BUSY        (BUSY)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    always @(posedge W_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge W_CLK) begin
        if (W_EN) begin
            wen_cyc.push_back(cyc);
            chk("wen_while_full", 64'(FULL), 64'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %0h expected none",
                         DATA_IN);
            end else begin
                chk("data_in", 64'(DATA_IN), 64'(exp_q.pop_front()));
            end
        end
        // S_READY low means a pending word is held against FULL.
        if (!S_READY && prev_stall) begin
            chk("hold_stable", 64'(DATA_IN), 64'(prev_data));
        end
        prev_stall = !S_READY && RST_N_W_CLK;
        prev_data  = DATA_IN;
    end

    task automatic send(input logic [IW-1:0] d, input logic l);
        bit ok;
        ok      = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = d;
        S_LAST  = l;
        for (int n = 0; n < 100; n++) begin
            @(negedge W_CLK);
            if (S_READY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got S_READY=0 expected 1");
        end
        @(posedge W_CLK);
        #1;
        S_VALID = 1'b0;
        S_DATA  = 8'hEE;
        S_LAST  = 1'b1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge W_CLK);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got BUSY=1 expected 0");
        end
    endtask

    task automatic do_reset();
        RST_N_W_CLK = 1'b0;
        repeat (2) @(posedge W_CLK);
        #1;
        RST_N_W_CLK = 1'b1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_wen"},   64'(W_EN),    64'd0);
        chk({name, "_data"},  64'(DATA_IN), 64'd0);
        chk({name, "_busy"},  64'(BUSY),    64'd0);
        chk({name, "_cnt"},   64'(PKT_CNT), 64'd0);
        chk({name, "_ready"}, 64'(S_READY), 64'd1);
    endtask

    initial begin
        int acc_cyc;
        int t0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        RST_N_W_CLK = 1'b0;
        S_VALID     = 1'b0;
        S_DATA      = '0;
        S_LAST      = 1'b0;
        FULL        = 1'b0;
        #1;
        chk_idle("reset");
        do_reset();
        chk_idle("post_reset");

        // Four-lane packet and write latency.
        exp_q.push_back({1'b1, 2'd3, 32'h44332211});
        wen_cyc.delete();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        acc_cyc = cyc;
        drain();
        chk("pkt4_cnt", 64'(PKT_CNT), 64'd1);
        chk("pkt4_wens", 64'(wen_cyc.size()), 64'd1);
        if (wen_cyc.size() > 0)
            chk("pkt4_latency", 64'(wen_cyc[0]), 64'(acc_cyc));

        // Short packets, including a one-lane packet.
        do_reset();
        exp_q.push_back({1'b1, 2'd1, 32'h0000BBAA});
        exp_q.push_back({1'b1, 2'd0, 32'h000000CC});
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
        drain();
        chk("short_cnt", 64'(PKT_CNT), 64'd2);

        // Backpressure: FULL high for five cycles from the third edge.
        do_reset();
        exp_q.push_back({1'b0, 2'd3, 32'h04030201});
        exp_q.push_back({1'b0, 2'd3, 32'h08070605});
        fork
            begin
                repeat (3) @(posedge W_CLK);
                #1 FULL = 1'b1;
                repeat (2) @(posedge W_CLK);
                @(negedge W_CLK);
                chk("stall_ready", 64'(S_READY), 64'd0);
                chk("stall_wen",   64'(W_EN),    64'd0);
                repeat (3) @(posedge W_CLK);
                #1 FULL = 1'b0;
            end
        join_none
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        drain();
        chk("stall_cnt", 64'(PKT_CNT), 64'd0);
        chk("stall_left", 64'(exp_q.size()), 64'd0);

        // Continuous stream: no stalls, writes every fourth cycle.
        do_reset();
        wen_cyc.delete();
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back({1'b1, 2'd3,
                             8'(16*w+4), 8'(16*w+3),
                             8'(16*w+2), 8'(16*w+1)});
        end
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(8'(16*(i/4) + i%4 + 1), (i%4) == 3);
        end
        chk("stream_cycles", 64'(cyc - t0), 64'd16);
        drain();
        chk("stream_wens", 64'(wen_cyc.size()), 64'd4);
        for (int k = 1; k < wen_cyc.size(); k++) begin
            chk("stream_gap", 64'(wen_cyc[k] - wen_cyc[k-1]), 64'd4);
        end
        chk("stream_cnt", 64'(PKT_CNT), 64'd4);

        // Reset mid-packet discards partial data.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        RST_N_W_CLK = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(posedge W_CLK);
        #1 RST_N_W_CLK = 1'b1;
        exp_q.push_back({1'b1, 2'd3, 32'h88776655});
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        drain();
        chk("mid_reset_cnt", 64'(PKT_CNT), 64'd1);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
